// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece controller: playfield geometry,
// piece encodings, rotation-0 shape table, FSM states and the spawn LFSR step.
package tetris_pkg;

  localparam int GRID_COLS = 10;
  localparam int GRID_ROWS = 20;
  localparam int COORD_W   = 5;
  localparam int TYPE_W    = 3;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [TYPE_W-1:0] {
    PT_O = 3'd0,
    PT_I = 3'd1,
    PT_T = 3'd2,
    PT_L = 3'd3,
    PT_J = 3'd4,
    PT_S = 3'd5,
    PT_Z = 3'd6
  } piece_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_FALL  = 3'd2,
    ST_LOCK  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // One square offset from the shape anchor; all offsets are non-negative.
  typedef struct packed {
    logic [1:0] dc;
    logic [1:0] dr;
  } offset_t;

  // Index 0 is square 1, index 3 is square 4.
  typedef offset_t [3:0] shape_t;

  function automatic offset_t ofs(input int dc, input int dr);
    offset_t o;
    o.dc = 2'(dc);
    o.dr = 2'(dr);
    return o;
  endfunction

  // Rotation-0 layout of every piece, anchor at the top-left of its bounding box.
  function automatic shape_t shape_offsets(input piece_t ptype);
    shape_t s;
    s[0] = ofs(0, 0);
    s[1] = ofs(1, 0);
    s[2] = ofs(0, 1);
    s[3] = ofs(1, 1);
    case (ptype)
      PT_O: begin s[0] = ofs(0, 0); s[1] = ofs(1, 0); s[2] = ofs(0, 1); s[3] = ofs(1, 1); end
      PT_I: begin s[0] = ofs(0, 0); s[1] = ofs(1, 0); s[2] = ofs(2, 0); s[3] = ofs(3, 0); end
      PT_T: begin s[0] = ofs(0, 0); s[1] = ofs(1, 0); s[2] = ofs(2, 0); s[3] = ofs(1, 1); end
      PT_L: begin s[0] = ofs(0, 0); s[1] = ofs(1, 0); s[2] = ofs(2, 0); s[3] = ofs(0, 1); end
      PT_J: begin s[0] = ofs(0, 0); s[1] = ofs(1, 0); s[2] = ofs(2, 0); s[3] = ofs(2, 1); end
      PT_S: begin s[0] = ofs(1, 0); s[1] = ofs(2, 0); s[2] = ofs(0, 1); s[3] = ofs(1, 1); end
      PT_Z: begin s[0] = ofs(0, 0); s[1] = ofs(1, 0); s[2] = ofs(1, 1); s[3] = ofs(2, 1); end
      default: ;
    endcase
    return s;
  endfunction

  // Fibonacci LFSR for x^3+x^2+1: 7-state cycle that never reaches zero.
  function automatic logic [2:0] lfsr_next(input logic [2:0] q);
    return {q[1:0], q[2] ^ q[1]};
  endfunction

endpackage

// File: rtl/falling_piece_ctrl_if.sv
// Signal bundle between the falling-piece controller (master) and its
// neighbours: key/timing inputs in, active-square coordinates and status out.
interface falling_piece_ctrl_if;
  import tetris_pkg::*;

  logic              vsync_in;
  logic              start;
  logic              move_left;
  logic              move_right;
  logic              drop_fast;
  logic              collision;

  coord_t            sq_1_col;
  coord_t            sq_2_col;
  coord_t            sq_3_col;
  coord_t            sq_4_col;
  coord_t            sq_1_row;
  coord_t            sq_2_row;
  coord_t            sq_3_row;
  coord_t            sq_4_row;
  logic [TYPE_W-1:0] piece_type;
  logic              piece_valid;
  logic              lock_pulse;
  logic              game_over;

  modport master (
    input  vsync_in, start, move_left, move_right, drop_fast, collision,
    output sq_1_col, sq_2_col, sq_3_col, sq_4_col,
    output sq_1_row, sq_2_row, sq_3_row, sq_4_row,
    output piece_type, piece_valid, lock_pulse, game_over
  );

  modport slave (
    output vsync_in, start, move_left, move_right, drop_fast, collision,
    input  sq_1_col, sq_2_col, sq_3_col, sq_4_col,
    input  sq_1_row, sq_2_row, sq_3_row, sq_4_row,
    input  piece_type, piece_valid, lock_pulse, game_over
  );

endinterface

// File: rtl/falling_piece_ctrl_frame_tick_gen.sv
// Frame strobe from the vsync rising edge and a strobe divider that emits
// one fall_tick per FALL_FRAMES (or FAST_FRAMES while drop_fast) strobes.
module frame_tick_gen #(
  parameter int FALL_FRAMES = 30,
  parameter int FAST_FRAMES = 2
) (
  input  logic pclk,
  input  logic rst,
  input  logic vsync_in,
  input  logic drop_fast,
  input  logic clr,
  output logic fall_tick
);

  localparam int MAX_FRAMES = (FALL_FRAMES > FAST_FRAMES) ? FALL_FRAMES : FAST_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  logic             vs_q;
  logic             vs_qq;
  logic             strobe;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] limit_m1;
  logic             at_limit;

  // Limit is chosen live, so a shorter limit with a larger count ticks at once.
  assign limit_m1  = drop_fast ? CNT_W'(FAST_FRAMES - 1) : CNT_W'(FALL_FRAMES - 1);
  assign at_limit  = (cnt_q >= limit_m1);
  assign strobe    = vs_q & ~vs_qq;
  assign fall_tick = strobe & at_limit & ~clr;

  // Edge-detect history and strobe counter; a clear wins over a strobe.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      cnt_q <= '0;
    end else begin
      vs_q  <= vsync_in;
      vs_qq <= vs_q;
      if (clr) begin
        cnt_q <= '0;
      end else if (strobe) begin
        cnt_q <= at_limit ? '0 : cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/falling_piece_ctrl.sv
// Active-tetromino owner: spawns pieces from an LFSR, drops them on fall
// ticks, shifts them on key pulses and locks them on floor or collision.
module falling_piece_ctrl
  import tetris_pkg::*;
#(
  parameter int SPAWN_COL    = 4,
  parameter int FALL_FRAMES  = 30,
  parameter int FAST_FRAMES  = 2,
  parameter int LIVE_ROW_MIN = 2
) (
  input  logic                 pclk,
  input  logic                 rst,
  falling_piece_ctrl_if.master pif
);

  state_t                  state_q;
  state_t                  state_nxt;
  logic [3:0][COORD_W-1:0] col_q;
  logic [3:0][COORD_W-1:0] row_q;
  logic [TYPE_W-1:0]       piece_type_q;
  logic                    piece_valid_q;
  logic                    lock_pulse_q;
  logic                    game_over_q;
  logic [2:0]              lfsr_q;
  logic                    fall_first_q;

  logic                    fall_tick;
  logic                    cnt_clr;
  coord_t                  min_col;
  coord_t                  max_col;
  coord_t                  min_row;
  coord_t                  max_row;
  logic                    in_fall;
  logic                    coll_hit;
  logic                    step_ok;
  logic                    at_floor;
  logic                    left_ok;
  logic                    right_ok;
  logic                    drop_ok;
  logic [TYPE_W-1:0]       spawn_type;
  shape_t                  spawn_shape;

  frame_tick_gen #(
    .FALL_FRAMES (FALL_FRAMES),
    .FAST_FRAMES (FAST_FRAMES)
  ) u_tick (
    .pclk      (pclk),
    .rst       (rst),
    .vsync_in  (pif.vsync_in),
    .drop_fast (pif.drop_fast),
    .clr       (cnt_clr),
    .fall_tick (fall_tick)
  );

  assign cnt_clr     = pif.start | (state_q == ST_SPAWN);
  assign spawn_type  = lfsr_q - 3'd1;
  assign spawn_shape = shape_offsets(piece_t'(spawn_type));

  // Bounding box of the active piece, used for wall, floor and top-out tests.
  always_comb begin
    min_col = col_q[0];
    max_col = col_q[0];
    min_row = row_q[0];
    max_row = row_q[0];
    for (int i = 1; i < 4; i++) begin
      if (col_q[i] < min_col) min_col = col_q[i];
      if (col_q[i] > max_col) max_col = col_q[i];
      if (row_q[i] < min_row) min_row = row_q[i];
      if (row_q[i] > max_row) max_row = row_q[i];
    end
  end

  // The collision flag lags by a cycle, so the first FALL cycle still sees the old piece.
  assign in_fall  = (state_q == ST_FALL) & ~pif.start;
  assign coll_hit = in_fall & ~fall_first_q & pif.collision;
  assign step_ok  = in_fall & ~coll_hit;
  assign at_floor = (max_row >= COORD_W'(GRID_ROWS - 1));
  assign left_ok  = step_ok & pif.move_left & ~pif.move_right & (min_col != '0);
  assign right_ok = step_ok & pif.move_right & ~pif.move_left &
                    (max_col < COORD_W'(GRID_COLS - 1));
  assign drop_ok  = step_ok & fall_tick & ~at_floor;

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic; start restarts the game from any state.
  always_comb begin
    state_nxt = state_q;
    if (pif.start) begin
      state_nxt = ST_SPAWN;
    end else begin
      case (state_q)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_SPAWN: state_nxt = ST_FALL;
        ST_FALL:  if (coll_hit || (fall_tick && at_floor)) state_nxt = ST_LOCK;
        ST_LOCK:  state_nxt = (min_row < COORD_W'(LIVE_ROW_MIN)) ? ST_OVER : ST_SPAWN;
        ST_OVER:  state_nxt = ST_OVER;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Piece registers: load on spawn, shift/drop while falling, release on lock.
  always_ff @(posedge pclk) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      piece_type_q  <= '0;
      piece_valid_q <= 1'b0;
      lock_pulse_q  <= 1'b0;
      game_over_q   <= 1'b0;
      lfsr_q        <= 3'b001;
      fall_first_q  <= 1'b0;
    end else begin
      lock_pulse_q <= (state_nxt == ST_LOCK);
      if (pif.start)                  game_over_q <= 1'b0;
      else if (state_nxt == ST_OVER)  game_over_q <= 1'b1;

      if (!pif.start) begin
        case (state_q)
          ST_SPAWN: begin
            piece_type_q  <= spawn_type;
            lfsr_q        <= lfsr_next(lfsr_q);
            piece_valid_q <= 1'b1;
            fall_first_q  <= 1'b1;
            for (int i = 0; i < 4; i++) begin
              col_q[i] <= COORD_W'(SPAWN_COL) + COORD_W'(spawn_shape[i].dc);
              row_q[i] <= COORD_W'(spawn_shape[i].dr);
            end
          end
          ST_FALL: begin
            fall_first_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
              if (left_ok)       col_q[i] <= col_q[i] - 1'b1;
              else if (right_ok) col_q[i] <= col_q[i] + 1'b1;
              if (drop_ok)       row_q[i] <= row_q[i] + 1'b1;
            end
          end
          ST_LOCK: piece_valid_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign pif.sq_1_col    = col_q[0];
  assign pif.sq_2_col    = col_q[1];
  assign pif.sq_3_col    = col_q[2];
  assign pif.sq_4_col    = col_q[3];
  assign pif.sq_1_row    = row_q[0];
  assign pif.sq_2_row    = row_q[1];
  assign pif.sq_3_row    = row_q[2];
  assign pif.sq_4_row    = row_q[3];
  assign pif.piece_type  = piece_type_q;
  assign pif.piece_valid = piece_valid_q;
  assign pif.lock_pulse  = lock_pulse_q;
  assign pif.game_over   = game_over_q;

endmodule

// File: tb/tb_falling_piece_ctrl.sv
// Bench for falling_piece_ctrl: directed scenarios followed by random key,
// vsync and collision traffic, all checked every cycle against a piece model.
module tb_falling_piece_ctrl;

  localparam int M_IDLE = 0, M_SPAWN = 1, M_FALL = 2, M_LOCK = 3, M_OVER = 4;

  logic pclk = 1'b0;
  logic rst;
  always #5 pclk = ~pclk;

  falling_piece_ctrl_if bus ();

  falling_piece_ctrl dut (
    .pclk (pclk),
    .rst  (rst),
    .pif  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int lock_seen = 0;

  // Piece order: LFSR values 1,2,5,3,7,6,4 from seed 001, each minus one.
  int seq_tbl [7] = '{0, 1, 4, 2, 6, 5, 3};
  // Bounding-box width/height per type O,I,T,L,J,S,Z.
  int shp_w [7] = '{2, 4, 3, 3, 3, 3, 3};
  int shp_h [7] = '{2, 1, 2, 2, 2, 2, 2};
  int ofs_c [7][4] = '{'{0,1,0,1}, '{0,1,2,3}, '{0,1,2,1}, '{0,1,2,0},
                       '{0,1,2,2}, '{1,2,0,1}, '{0,1,1,2}};
  int ofs_r [7][4] = '{'{0,0,1,1}, '{0,0,0,0}, '{0,0,0,1}, '{0,0,0,1},
                       '{0,0,0,1}, '{0,0,1,1}, '{0,0,1,1}};

  // Reference model: piece anchor + type, frame counter, game mode.
  int m_mode, m_type, m_ac, m_ar, m_cnt, m_seq_i;
  bit m_loaded, m_valid, m_lock, m_over, m_fresh, m_vs1, m_vs2;

  always @(posedge pclk) begin
    bit strobe;
    bit tick;
    int limit;
    strobe = m_vs1 && !m_vs2;
    tick   = 1'b0;
    limit  = bus.drop_fast ? 2 : 30;
    if (rst) begin
      m_mode = M_IDLE; m_type = 0; m_ac = 0; m_ar = 0; m_cnt = 0; m_seq_i = 0;
      m_loaded = 0; m_valid = 0; m_lock = 0; m_over = 0; m_fresh = 0;
      m_vs1 = 0; m_vs2 = 0;
    end else begin
      if (strobe) begin
        m_cnt++;
        if (m_cnt >= limit) begin tick = 1'b1; m_cnt = 0; end
      end
      m_vs2 = m_vs1;
      m_vs1 = bus.vsync_in;
      if (bus.start) begin
        m_mode = M_SPAWN; m_over = 0; m_cnt = 0;
      end else begin
        case (m_mode)
          M_SPAWN: begin
            m_type = seq_tbl[m_seq_i]; m_seq_i = (m_seq_i + 1) % 7;
            m_ac = 4; m_ar = 0; m_loaded = 1; m_valid = 1; m_cnt = 0;
            m_fresh = 1; m_mode = M_FALL;
          end
          M_FALL: begin
            if (!m_fresh && bus.collision) begin
              m_mode = M_LOCK;
            end else begin
              if (bus.move_left && !bus.move_right && m_ac > 0) m_ac--;
              else if (bus.move_right && !bus.move_left && m_ac + shp_w[m_type] < 10) m_ac++;
              if (tick) begin
                if (m_ar + shp_h[m_type] < 20) m_ar++;
                else m_mode = M_LOCK;
              end
            end
            m_fresh = 0;
          end
          M_LOCK: begin
            m_valid = 0;
            if (m_ar < 2) begin m_mode = M_OVER; m_over = 1; end
            else m_mode = M_SPAWN;
          end
          default: ;
        endcase
      end
      m_lock = (m_mode == M_LOCK);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] dut_cols();
    return {bus.sq_4_col, bus.sq_3_col, bus.sq_2_col, bus.sq_1_col};
  endfunction

  function automatic logic [19:0] dut_rows();
    return {bus.sq_4_row, bus.sq_3_row, bus.sq_2_row, bus.sq_1_row};
  endfunction

  task automatic compare_all();
    logic [19:0] ec, er;
    for (int i = 0; i < 4; i++) begin
      ec[i*5 +: 5] = m_loaded ? 5'(m_ac + ofs_c[m_type][i]) : 5'd0;
      er[i*5 +: 5] = m_loaded ? 5'(m_ar + ofs_r[m_type][i]) : 5'd0;
    end
    check_eq("sq_cols", dut_cols(), ec);
    check_eq("sq_rows", dut_rows(), er);
    check_eq("piece_type", bus.piece_type, m_type);
    check_eq("piece_valid", bus.piece_valid, m_valid);
    check_eq("lock_pulse", bus.lock_pulse, m_lock);
    check_eq("game_over", bus.game_over, m_over);
    if (bus.lock_pulse) lock_seen++;
  endtask

  task automatic cyc();
    @(negedge pclk);
    compare_all();
  endtask

  task automatic vpulse(input int hi, input int lo);
    bus.vsync_in = 1'b1;
    repeat (hi) cyc();
    bus.vsync_in = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic key(input bit l, input bit r);
    bus.move_left = l; bus.move_right = r;
    cyc();
    bus.move_left = 1'b0; bus.move_right = 1'b0;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.vsync_in = 0; bus.start = 0; bus.move_left = 0; bus.move_right = 0;
    bus.drop_fast = 0; bus.collision = 0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    check_eq("rst_valid", bus.piece_valid, 0);
    check_eq("rst_cols", dut_cols(), 0);

    // Spawn: O at (4,0)(5,0)(4,1)(5,1)
    bus.start = 1; cyc(); bus.start = 0; cyc();
    check_eq("t1_type", bus.piece_type, 0);
    check_eq("t1_cols", dut_cols(), {5'd5, 5'd4, 5'd5, 5'd4});
    check_eq("t1_rows", dut_rows(), {5'd1, 5'd1, 5'd0, 5'd0});
    check_eq("t1_valid", bus.piece_valid, 1);

    // Normal rate: one row after 30 frames; fast rate: one row per 2 frames
    repeat (29) vpulse(2, 2);
    check_eq("t2_row_29", bus.sq_1_row, 0);
    vpulse(2, 2);
    check_eq("t2_row_30", bus.sq_1_row, 1);
    bus.drop_fast = 1;
    repeat (2) vpulse(2, 2);
    check_eq("t2_fast_a", bus.sq_1_row, 2);
    repeat (2) vpulse(2, 2);
    check_eq("t2_fast_b", bus.sq_1_row, 3);

    // Collision lock low enough to respawn; next piece is I
    bus.collision = 1; cyc(); bus.collision = 0;
    repeat (3) cyc();
    check_eq("t3_type_i", bus.piece_type, 1);
    repeat (4) key(1, 0);
    check_eq("t3_at_wall", bus.sq_1_col, 0);
    key(1, 0);
    check_eq("t3_left_blocked", bus.sq_1_col, 0);
    key(0, 1);
    check_eq("t3_right", dut_cols(), {5'd4, 5'd3, 5'd2, 5'd1});
    key(1, 1);
    check_eq("t3_both", bus.sq_1_col, 1);

    // Ride to the floor: 20th tick finds max row 19 and locks
    lock_seen = 0;
    repeat (38) vpulse(2, 2);
    check_eq("t4_floor_row", bus.sq_1_row, 19);
    repeat (2) vpulse(2, 2);
    repeat (4) cyc();
    check_eq("t4_lock_once", lock_seen, 1);
    check_eq("t4_new_type", bus.piece_type, 4);
    check_eq("t4_respawn_row", bus.sq_1_row, 0);

    // Collision near the top: game over, inputs ignored, then restart
    bus.collision = 1; cyc(); bus.collision = 0;
    repeat (3) cyc();
    check_eq("t5_over", bus.game_over, 1);
    check_eq("t5_valid", bus.piece_valid, 0);
    key(1, 0);
    repeat (4) vpulse(2, 2);
    check_eq("t5_frozen", bus.sq_1_col, 4);
    bus.start = 1; cyc(); bus.start = 0; cyc();
    check_eq("t5_over_clr", bus.game_over, 0);
    check_eq("t5_respawn", bus.piece_type, 2);
    bus.collision = 1; cyc(); bus.collision = 0; cyc();
    check_eq("t5_first_coll_ignored", bus.piece_valid, 1);

    // Reset mid-fall
    repeat (3) vpulse(2, 2);
    rst = 1; cyc();
    check_eq("t6_valid", bus.piece_valid, 0);
    check_eq("t6_rows", dut_rows(), 0);
    check_eq("t6_type", bus.piece_type, 0);
    rst = 0; cyc();
    bus.start = 1; cyc(); bus.start = 0; cyc();
    check_eq("t6_reseed", bus.piece_type, 0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      bus.move_left  = ($urandom_range(0, 7) == 0);
      bus.move_right = ($urandom_range(0, 7) == 0);
      bus.collision  = ($urandom_range(0, 39) == 0);
      bus.start      = ($urandom_range(0, 399) == 0);
      rst            = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 99) == 0) bus.drop_fast = ~bus.drop_fast;
      if ($urandom_range(0, 2) == 0)  bus.vsync_in  = ~bus.vsync_in;
      cyc();
    end
    rst = 0; bus.start = 0; bus.move_left = 0; bus.move_right = 0; bus.collision = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
